// File: rtl/demux_tdm_4_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
// Holds the auto-mode FSM state type, channel indices and default data width.
package demux_tdm_4_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
        return 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/demux_tdm_4_if.sv
// Bus bundle between a word source/frame sink and demux_tdm_4.
// The master modport is the source side; the slave modport is the demux.
interface demux_tdm_4_if import demux_tdm_4_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             mode;
    logic [1:0]       selector;
    logic [WIDTH-1:0] I;
    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic [3:0]       valid_o;
    logic             frame_valid;

    modport master (
        output mode, selector, I, in_valid, out_ready,
        input  in_ready, A, B, C, D, valid_o, frame_valid
    );

    modport slave (
        input  mode, selector, I, in_valid, out_ready,
        output in_ready, A, B, C, D, valid_o, frame_valid
    );
endinterface

// File: rtl/demux_tdm_4_slot_counter.sv
// 2-bit wrapping slot index with synchronous clear and count enable.
// Clear takes effect first, so clear+enable on one edge yields 1.
module slot_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [1:0] o_slot
);
    logic [1:0] r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= 2'd0;
        end else begin
            r_slot <= (i_clr ? 2'd0 : r_slot) + {1'b0, i_en};
        end
    end

    assign o_slot = r_slot;
endmodule

// File: rtl/demux_tdm_4.sv
// Four-channel demux: directed routing by selector, or auto round-robin
// assembly of 4-word frames that are held on A-D until the sink takes them.
module demux_tdm_4 import demux_tdm_4_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    demux_tdm_4_if.slave  bus
);
    logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
    logic [WIDTH-1:0] r_stg0, r_stg1, r_stg2;
    logic [3:0]       r_vo;
    logic             r_fv;
    logic             r_mode_q;
    state_t           r_state;

    logic             w_mode_chg;
    logic             w_in_ready;
    logic             w_acc;
    logic [1:0]       w_slot;
    logic [1:0]       w_slot_eff;
    state_t           w_state_eff;

    // A mode change restarts assembly on the same edge, so the presented word
    // is evaluated against a cleared slot and FILL state.
    assign w_mode_chg  = bus.mode ^ r_mode_q;
    assign w_in_ready  = rst_n & (~bus.mode | (r_state == FILL) | bus.out_ready);
    assign w_acc       = bus.in_valid & w_in_ready;
    assign w_slot_eff  = w_mode_chg ? 2'd0 : w_slot;
    assign w_state_eff = w_mode_chg ? FILL : r_state;

    slot_counter u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_mode_chg),
        .i_en   (bus.mode & w_acc),
        .o_slot (w_slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_stg0   <= '0;
            r_stg1   <= '0;
            r_stg2   <= '0;
            r_vo     <= 4'b0000;
            r_fv     <= 1'b0;
            r_mode_q <= 1'b0;
            r_state  <= FILL;
        end else begin
            r_mode_q <= bus.mode;
            r_vo     <= 4'b0000;
            if (w_mode_chg) begin
                r_stg0  <= '0;
                r_stg1  <= '0;
                r_stg2  <= '0;
                r_fv    <= 1'b0;
                r_state <= FILL;
            end
            if (!bus.mode) begin
                if (w_acc) begin
                    r_vo <= ch_onehot(bus.selector);
                    case (bus.selector)
                        CH_A:    r_a <= bus.I;
                        CH_B:    r_b <= bus.I;
                        CH_C:    r_c <= bus.I;
                        default: r_d <= bus.I;
                    endcase
                end
            end else if (w_state_eff == FILL) begin
                if (w_acc) begin
                    case (w_slot_eff)
                        2'd0:    r_stg0 <= bus.I;
                        2'd1:    r_stg1 <= bus.I;
                        2'd2:    r_stg2 <= bus.I;
                        default: begin
                            r_a     <= r_stg0;
                            r_b     <= r_stg1;
                            r_c     <= r_stg2;
                            r_d     <= bus.I;
                            r_vo    <= 4'b1111;
                            r_fv    <= 1'b1;
                            r_state <= HOLD;
                        end
                    endcase
                end
            end else if (bus.out_ready) begin
                // Release and refill overlap: a word accepted now is slot 0.
                r_fv    <= 1'b0;
                r_state <= FILL;
                if (w_acc) r_stg0 <= bus.I;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.A           = r_a;
    assign bus.B           = r_b;
    assign bus.C           = r_c;
    assign bus.D           = r_d;
    assign bus.valid_o     = r_vo;
    assign bus.frame_valid = r_fv;
endmodule

// File: tb/tb_demux_tdm_4.sv
// Directed-vector bench for demux_tdm_4: a vector table for directed and
// auto/backpressure traffic, then hand sequences for mode switch, reset, gaps.
module tb_demux_tdm_4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_tdm_4_if #(.WIDTH(4)) bus ();

    demux_tdm_4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] d;
        logic       vld;
        logic       ordy;
        logic       erdy;
        logic [3:0] ea, eb, ec, ed, evo;
        logic       efv;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vt [20];

    function automatic vec_t mk(logic m, logic [1:0] s, logic [3:0] d, logic v, logic o,
                                logic r, logic [15:0] abcd, logic [3:0] vo, logic fv);
        vec_t x;
        x.mode = m; x.sel = s; x.d = d; x.vld = v; x.ordy = o; x.erdy = r;
        x.ea = abcd[15:12]; x.eb = abcd[11:8]; x.ec = abcd[7:4]; x.ed = abcd[3:0];
        x.evo = vo; x.efv = fv;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] abcd,
                           input logic [3:0] vo, input logic fv);
        chk({tag, ".A"}, 32'(bus.A), 32'(abcd[15:12]));
        chk({tag, ".B"}, 32'(bus.B), 32'(abcd[11:8]));
        chk({tag, ".C"}, 32'(bus.C), 32'(abcd[7:4]));
        chk({tag, ".D"}, 32'(bus.D), 32'(abcd[3:0]));
        chk({tag, ".valid_o"}, 32'(bus.valid_o), 32'(vo));
        chk({tag, ".frame_valid"}, 32'(bus.frame_valid), 32'(fv));
    endtask

    task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] d,
                         input logic v, input logic o);
        bus.mode = m; bus.selector = s; bus.I = d; bus.in_valid = v; bus.out_ready = o;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic m, input logic [1:0] s, input logic [3:0] d,
                        input logic v, input logic o);
        drive(m, s, d, v, o);
        step();
    endtask

    initial begin
        // directed (REQ-030), then rewrite channels to 1,2,3,4
        vt[0]  = mk(0, 2'd0, 4'hC, 1, 0, 1, 16'hC000, 4'b0001, 0);
        vt[1]  = mk(0, 2'd1, 4'hB, 1, 0, 1, 16'hCB00, 4'b0010, 0);
        vt[2]  = mk(0, 2'd2, 4'h9, 1, 0, 1, 16'hCB90, 4'b0100, 0);
        vt[3]  = mk(0, 2'd3, 4'hE, 1, 0, 1, 16'hCB9E, 4'b1000, 0);
        vt[4]  = mk(0, 2'd0, 4'h5, 0, 0, 1, 16'hCB9E, 4'b0000, 0);
        vt[5]  = mk(0, 2'd0, 4'h1, 1, 0, 1, 16'h1B9E, 4'b0001, 0);
        vt[6]  = mk(0, 2'd1, 4'h2, 1, 0, 1, 16'h129E, 4'b0010, 0);
        vt[7]  = mk(0, 2'd2, 4'h3, 1, 0, 1, 16'h123E, 4'b0100, 0);
        vt[8]  = mk(0, 2'd3, 4'h4, 1, 0, 1, 16'h1234, 4'b1000, 0);
        // auto with backpressure (REQ-031)
        vt[9]  = mk(1, 2'd3, 4'hC, 1, 0, 1, 16'h1234, 4'b0000, 0);
        vt[10] = mk(1, 2'd3, 4'hB, 1, 0, 1, 16'h1234, 4'b0000, 0);
        vt[11] = mk(1, 2'd3, 4'h9, 1, 0, 1, 16'h1234, 4'b0000, 0);
        vt[12] = mk(1, 2'd3, 4'hE, 1, 0, 1, 16'hCB9E, 4'b1111, 1);
        vt[13] = mk(1, 2'd0, 4'h1, 1, 0, 0, 16'hCB9E, 4'b0000, 1);
        vt[14] = mk(1, 2'd0, 4'h1, 1, 0, 0, 16'hCB9E, 4'b0000, 1);
        vt[15] = mk(1, 2'd0, 4'h1, 1, 1, 1, 16'hCB9E, 4'b0000, 0);
        vt[16] = mk(1, 2'd0, 4'h2, 1, 1, 1, 16'hCB9E, 4'b0000, 0);
        vt[17] = mk(1, 2'd0, 4'h3, 1, 1, 1, 16'hCB9E, 4'b0000, 0);
        vt[18] = mk(1, 2'd0, 4'h4, 1, 1, 1, 16'h1234, 4'b1111, 1);
        vt[19] = mk(1, 2'd0, 4'h0, 0, 1, 1, 16'h1234, 4'b0000, 0);

        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            step();
            chk_out("rst_hold", 16'h0000, 4'b0000, 0);
            chk("rst_hold.in_ready", 32'(bus.in_ready), 32'd0);
        end
        drive(0, 2'd0, 4'h0, 0, 0);
        #2 rst_n = 1'b1;
        #1 chk("rst_rel.in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].mode, vt[i].sel, vt[i].d, vt[i].vld, vt[i].ordy);
            #1 chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vt[i].erdy));
            step();
            chk_out($sformatf("vec%0d", i), {vt[i].ea, vt[i].eb, vt[i].ec, vt[i].ed},
                    vt[i].evo, vt[i].efv);
        end

        // mid-frame switch to directed and back
        send(1, 2'd0, 4'h5, 1, 0);
        send(1, 2'd0, 4'h6, 1, 0);
        send(0, 2'd2, 4'h7, 1, 0);
        chk_out("msw_dir", 16'h1274, 4'b0100, 0);
        send(1, 2'd0, 4'h8, 1, 0);
        send(1, 2'd0, 4'h9, 1, 0);
        send(1, 2'd0, 4'hA, 1, 0);
        chk_out("msw_3words", 16'h1274, 4'b0000, 0);
        send(1, 2'd0, 4'hB, 1, 0);
        chk_out("msw_frame", 16'h89AB, 4'b1111, 1);
        send(1, 2'd0, 4'h0, 0, 1);
        chk("msw_release.fv", 32'(bus.frame_valid), 32'd0);

        // async reset between edges after 3 auto words
        send(1, 2'd0, 4'h1, 1, 0);
        send(1, 2'd0, 4'h2, 1, 0);
        send(1, 2'd0, 4'h3, 1, 0);
        #2 rst_n = 1'b0;
        #1 chk_out("arst", 16'h0000, 4'b0000, 0);
        chk("arst.in_ready", 32'(bus.in_ready), 32'd0);
        step();
        #2 rst_n = 1'b1;
        #1 chk("arst_rel.in_ready", 32'(bus.in_ready), 32'd1);
        send(1, 2'd0, 4'h4, 1, 0);
        send(1, 2'd0, 4'h5, 1, 0);
        send(1, 2'd0, 4'h6, 1, 0);
        chk_out("arst_3words", 16'h0000, 4'b0000, 0);
        send(1, 2'd0, 4'h7, 1, 0);
        chk_out("arst_frame", 16'h4567, 4'b1111, 1);

        // gapped input: valid every other cycle, junk data on idle cycles
        send(1, 2'd0, 4'h0, 0, 1);
        chk("gap_release.fv", 32'(bus.frame_valid), 32'd0);
        for (int k = 0; k < 7; k++) begin
            if (k % 2 == 0) send(1, 2'd0, 4'(8 + k / 2), 1, 1);
            else            send(1, 2'd0, 4'hF, 0, 1);
            if (k < 6) chk_out($sformatf("gap%0d", k), 16'h4567, 4'b0000, 0);
            else       chk_out("gap_frame", 16'h89AB, 4'b1111, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_tdm_4.md
DEMUX_TDM_4 -- requirements
Module: demux_tdm_4

Interface
REQ-001 Parameter: WIDTH, default 4, data width of the input word and of each output channel.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mode  input  1  0 = directed (selector routes each word), 1 = auto round-robin frame assembly.
REQ-005 selector  input  2  target channel in directed mode (00=A, 01=B, 10=C, 11=D); ignored in auto mode.
REQ-006 I  input  WIDTH  input data word.
REQ-007 in_valid  input  1  I is valid this cycle.
REQ-008 in_ready  output  1  block accepts I this cycle; a word is accepted when in_valid && in_ready at a rising edge.
REQ-009 out_ready  input  1  downstream consumes a held frame (auto mode).
REQ-010 A, B, C, D  output  WIDTH each  registered channel outputs.
REQ-011 valid_o  output  4  one-cycle per-channel update strobes; bit0=A … bit3=D.
REQ-012 frame_valid  output  1  auto mode: complete frame present on A-D, held until consumed.

Function
REQ-013 Directed mode: an accepted word is written to the channel named by selector at that edge; other channels hold; the matching valid_o bit is high for exactly the following cycle.
REQ-014 Directed mode: in_ready is constantly 1; frame_valid is 0.
REQ-015 Auto mode: FSM with states FILL and HOLD; 2-bit slot counter counts accepted words 0..3.
REQ-016 FILL: accepted words at slots 0-2 go to staging registers; A-D do not change.
REQ-017 FILL, slot 3 accepted: at that same edge A<=slot0, B<=slot1, C<=slot2, D<=I; valid_o=4'b1111 for one cycle; frame_valid<=1; slot<=0; state<=HOLD.
REQ-018 HOLD: in_ready = out_ready; A-D and frame_valid are stable while out_ready=0.
REQ-019 HOLD with out_ready=1 and no accept: frame_valid<=0, state<=FILL.
REQ-020 HOLD with out_ready=1 and simultaneous accept: frame_valid<=0, state<=FILL, accepted word stored as slot 0, slot<=1 (no word lost, no bubble).
REQ-021 Slot counter wraps 3->0 only through REQ-017; it never advances on a cycle without an accept.
REQ-022 in_valid without in_ready: word dropped, no state change; the source holds it.
REQ-023 mode change (any edge where mode differs from the previous cycle's value): staging and slot cleared to 0, state<=FILL, frame_valid<=0; A-D keep their values; the word, if any, presented on that edge is processed under the new mode.
REQ-024 All outputs are registers except in_ready, which is combinational from state, mode and out_ready.

Reset
REQ-025 rst_n low asynchronously forces A=B=C=D=0, valid_o=0, frame_valid=0, staging=0, slot=0, state=FILL, regardless of clk.
REQ-026 in_ready is 0 while rst_n is low and follows REQ-014/REQ-018 from the first edge after deassertion; reset mid-frame discards partial frames.

Structure
REQ-027 Shared package holds: FSM state type (FILL, HOLD), channel-index constants CH_A..CH_D (2'b00..2'b11), default WIDTH.
REQ-028 One sub-module, slot_counter (2-bit wrap counter with clear and enable), is used for the slot index; the FSM and channel registers stay in the top module.

Verification
REQ-029 Reset: hold rst_n=0 with random inputs -> A-D=0, valid_o=0, frame_valid=0, in_ready=0; release -> in_ready=1.
REQ-030 Directed: mode=0; send 1100/sel 00, 1011/01, 1001/10, 1110/11 -> A=12, B=11, C=9, D=14; valid_o pulses 0001, 0010, 0100, 1000 in successive cycles.
REQ-031 Auto with backpressure: mode=1, out_ready=0, stream 1100,1011,1001,1110,0001 -> after the 4th word A-D=12,11,9,14, frame_valid=1, in_ready=0, 5th word waits; out_ready=1 -> 5th word accepted as slot 0 in the same cycle, frame_valid=0.
REQ-032 Mid-frame mode switch: mode=1, send 2 words, set mode=0 -> slot cleared; next directed word to sel 10 updates only C; back to mode=1 needs 4 fresh words before frame_valid.
REQ-033 Async reset mid-frame: assert rst_n between clock edges after 3 auto words -> outputs clear immediately; after release, 4 new words are required for a frame.
REQ-034 Gapped input: auto mode with in_valid toggling every other cycle -> slot counter advances only on accepts; frame completes after exactly 4 accepts.
